ssr4_to_ssr6_gearbox: RTL and testbench



---
 rtl/ssr4_to_ssr6_gearbox_pkg.sv | 15 +
 rtl/ssr4_to_ssr6_gearbox_phase_tracker.sv | 49 ++++
 rtl/ssr4_to_ssr6_gearbox.sv | 83 ++++++++
 tb/tb_ssr4_to_ssr6_gearbox.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ssr4_to_ssr6_gearbox_pkg.sv
// Shared definitions for the SSR4/SSR6 gearbox pair and its phase tracker.
// Both converters rely on the same 3-clock frame, so the constants live here.
package ssr4_to_ssr6_gearbox_pkg;

    localparam int SSR4_N     = 4;
    localparam int SSR6_N     = 6;
    localparam int FRAME_CLKS = 3;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } ssr_phase_e;

endpackage

// File: rtl/ssr4_to_ssr6_gearbox_phase_tracker.sv
// Frame phase tracker driven by the global clk_phase_i marker.
// It free-runs through missing pulses and realigns, with a sticky error, on a misplaced pulse.
module ssr_phase_tracker
    import ssr4_to_ssr6_gearbox_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk_phase_i,
    output ssr_phase_e phase_o,
    output logic       locked_o,
    output logic       phase_err_o
);

    ssr_phase_e ph_q, ph_d;
    ssr_phase_e cur_phase;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic       misalign;

    always_comb begin
        cur_phase = clk_phase_i ? PH0 : ph_q;
        // Before the first pulse the counter has no meaning, so a pulse cannot be misaligned.
        misalign  = clk_phase_i && locked_q && (ph_q != PH0);
        if (cur_phase == ssr_phase_e'(2'(FRAME_CLKS - 1))) begin
            ph_d = PH0;
        end else begin
            ph_d = ssr_phase_e'(cur_phase + 2'd1);
        end
        locked_d = locked_q | clk_phase_i;
        err_d    = err_q | misalign;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ph_q     <= PH0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ph_q     <= ph_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign phase_o     = cur_phase;
    assign locked_o    = locked_q;
    assign phase_err_o = err_q;

endmodule

// File: rtl/ssr4_to_ssr6_gearbox.sv
// 4-samples/clock to 6-samples/clock gearbox: each 3-clock frame of 12 samples
// leaves as two 6-sample vectors on frame phases 1 and 2, qualified by ce_o.
module ssr4_to_ssr6_gearbox
    import ssr4_to_ssr6_gearbox_pkg::*;
#(
    parameter int INBITS = 12
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clk_phase_i,
    input  logic [SSR4_N-1:0][INBITS-1:0]  dat_i,
    output logic [SSR6_N-1:0][INBITS-1:0]  dat_o,
    output logic                           ce_o,
    output logic                           phase_err_o
);

    localparam int NIN  = SSR4_N;
    localparam int NOUT = SSR6_N;

    ssr_phase_e cur_phase;
    logic       locked;

    logic [NIN-1:0][INBITS-1:0]  hold0_q, hold0_d;
    logic [1:0][INBITS-1:0]      hold1_q, hold1_d;
    logic [NOUT-1:0][INBITS-1:0] dat_q, dat_d;
    logic                        ce_q, ce_d;

    ssr_phase_tracker u_phase_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clk_phase_i (clk_phase_i),
        .phase_o     (cur_phase),
        .locked_o    (locked),
        .phase_err_o (phase_err_o)
    );

    // Phase 0 only captures; the output vector is never touched on that edge.
    always_comb begin
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        dat_d   = dat_q;
        ce_d    = 1'b0;
        case (cur_phase)
            PH0: begin
                hold0_d = dat_i;
            end
            PH1: begin
                if (locked) begin
                    dat_d   = {dat_i[1], dat_i[0], hold0_q};
                    hold1_d = {dat_i[3], dat_i[2]};
                    ce_d    = 1'b1;
                end
            end
            PH2: begin
                if (locked) begin
                    dat_d = {dat_i, hold1_q};
                    ce_d  = 1'b1;
                end
            end
            default: begin
                ce_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold0_q <= '0;
            hold1_q <= '0;
            dat_q   <= '0;
            ce_q    <= 1'b0;
        end else begin
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            dat_q   <= dat_d;
            ce_q    <= ce_d;
        end
    end

    assign dat_o = dat_q;
    assign ce_o  = ce_q;

endmodule

// File: tb/tb_ssr4_to_ssr6_gearbox.sv
// Directed bench for ssr4_to_ssr6_gearbox: a ramp, reset release, missing and
// misplaced frame pulses, mid-frame reset and sign-extreme samples.
module tb_ssr4_to_ssr6_gearbox;

    localparam int W  = 12;
    localparam int EW = 32 + 6 * W;

    logic                clk;
    logic                rst;
    logic                clk_phase;
    logic [3:0][W-1:0]   dat_i;
    logic [5:0][W-1:0]   dat_o;
    logic                ce_o;
    logic                phase_err_o;

    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n        = 0;

    // Each entry: {edge number after which ce_o must be high, expected dat_o}.
    logic [EW-1:0] exp_q[$];

    ssr4_to_ssr6_gearbox #(.INBITS(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clk_phase_i (clk_phase),
        .dat_i       (dat_i),
        .dat_o       (dat_o),
        .ce_o        (ce_o),
        .phase_err_o (phase_err_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- helpers ----------------
    function automatic logic [3:0][W-1:0] ramp4(input int base);
        logic [3:0][W-1:0] v;
        for (int i = 0; i < 4; i++) v[i] = W'(base + i);
        return v;
    endfunction

    function automatic logic [5:0][W-1:0] ramp6(input int base);
        logic [5:0][W-1:0] v;
        for (int i = 0; i < 6; i++) v[i] = W'(base + i);
        return v;
    endfunction

    task automatic check(input string name, input logic [6*W-1:0] act, input logic [6*W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic r, input logic p, input logic [3:0][W-1:0] d);
        rst       = r;
        clk_phase = p;
        dat_i     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic ramp_cyc(input logic r, input logic p);
        cyc(r, p, ramp4(4 * n));
        n++;
    endtask

    // Expectation for the edge that the next cyc() call will produce.
    task automatic push(input logic [5:0][W-1:0] v);
        exp_q.push_back({32'(edge_cnt + 1), v});
    endtask

    task automatic ramp_frame(input logic p);
        int b;
        b = 4 * n;
        ramp_cyc(1'b0, p);
        push(ramp6(b));
        ramp_cyc(1'b0, 1'b0);
        push(ramp6(b + 6));
        ramp_cyc(1'b0, 1'b0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        while (exp_q.size() > 0 && exp_q[0][EW-1:6*W] < edge_cnt) begin
            e = exp_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missed_ce: no ce_o at edge %0d, expected data %h", e[EW-1:6*W], e[6*W-1:0]);
        end
        if (ce_o !== 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0 || exp_q[0][EW-1:6*W] != edge_cnt) begin
                n_errors++;
                $display("FAIL unexpected_ce: ce_o=%b at edge %0d with dat_o %h, none expected", ce_o, edge_cnt, dat_o);
            end else begin
                e = exp_q.pop_front();
                if (dat_o !== e[6*W-1:0]) begin
                    n_errors++;
                    $display("FAIL dat_o: got %h expected %h at edge %0d", dat_o, e[6*W-1:0], edge_cnt);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0][W-1:0] sgn_in;
    logic [5:0][W-1:0] sgn_e1, sgn_e2;
    int                b0;

    initial begin
        rst       = 1'b1;
        clk_phase = 1'b0;
        dat_i     = '0;
        sgn_in    = {12'h800, 12'h7FF, 12'hFFF, 12'h001};
        sgn_e1    = {12'hFFF, 12'h001, 12'h800, 12'h7FF, 12'hFFF, 12'h001};
        sgn_e2    = {12'h800, 12'h7FF, 12'hFFF, 12'h001, 12'h800, 12'h7FF};

        // Reset for 5 cycles; a pulse coinciding with reset must not lock.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, i == 4, {W'($urandom), W'($urandom), W'($urandom), W'($urandom)});
        end
        check("reset_dat_o", dat_o, '0);
        check("reset_ce_o", 72'(ce_o), 72'(0));
        check("reset_phase_err", 72'(phase_err_o), 72'(0));

        // Seven pulse-free cycles: still unlocked, nothing comes out.
        for (int i = 0; i < 7; i++) begin
            ramp_cyc(1'b0, 1'b0);
            check("unlocked_dat_o", dat_o, '0);
        end

        // First pulse; ce_o must rise exactly two cycles later.
        b0 = 4 * n;
        ramp_cyc(1'b0, 1'b1);
        check("pulse_edge_dat_o", dat_o, '0);
        check("pulse_edge_ce_o", 72'(ce_o), 72'(0));
        push(ramp6(b0));
        ramp_cyc(1'b0, 1'b0);
        push(ramp6(b0 + 6));
        ramp_cyc(1'b0, 1'b0);
        for (int f = 0; f < 999; f++) ramp_frame(1'b1);
        check("ramp_phase_err", 72'(phase_err_o), 72'(0));

        // Missing pulses for 4 frames: free-run, not an error.
        for (int f = 0; f < 4; f++) ramp_frame(1'b0);
        for (int f = 0; f < 3; f++) ramp_frame(1'b1);
        check("missing_phase_err", 72'(phase_err_o), 72'(0));

        // Extra pulse on a phase 1 cycle: that frame is dropped, realign there.
        ramp_cyc(1'b0, 1'b1);
        b0 = 4 * n;
        ramp_cyc(1'b0, 1'b1);
        check("misalign_ce_o", 72'(ce_o), 72'(0));
        check("misalign_phase_err", 72'(phase_err_o), 72'(1));
        push(ramp6(b0));
        ramp_cyc(1'b0, 1'b0);
        push(ramp6(b0 + 6));
        ramp_cyc(1'b0, 1'b0);
        for (int f = 0; f < 3; f++) ramp_frame(1'b1);
        check("misalign_err_sticky", 72'(phase_err_o), 72'(1));

        // Reset on a phase 1 cycle clears everything including the sticky error.
        ramp_cyc(1'b0, 1'b1);
        ramp_cyc(1'b1, 1'b0);
        check("midreset_dat_o", dat_o, '0);
        check("midreset_ce_o", 72'(ce_o), 72'(0));
        check("midreset_phase_err", 72'(phase_err_o), 72'(0));
        ramp_cyc(1'b0, 1'b0);
        ramp_cyc(1'b0, 1'b0);
        check("midreset_idle_dat_o", dat_o, '0);
        for (int f = 0; f < 3; f++) ramp_frame(1'b1);
        check("midreset_phase_err_after", 72'(phase_err_o), 72'(0));

        // Sign extremes moved bit-exact.
        for (int f = 0; f < 3; f++) begin
            cyc(1'b0, 1'b1, sgn_in);
            push(sgn_e1);
            cyc(1'b0, 1'b0, sgn_in);
            push(sgn_e2);
            cyc(1'b0, 1'b0, sgn_in);
        end

        // Park in reset so the free-running frame stops producing output.
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        @(negedge clk);
        #1;
        check("queue_drained", 72'(exp_q.size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
